// File: rtl/modn_event_counter_fsm_if.sv
// Control/status bundle for modn_event_counter_fsm: event stimulus in, terminal flag,
// count and busy out. CW must equal $clog2(MODULUS) of the attached counter.
interface modn_event_counter_fsm_if #(
  parameter int CW = 2
);
  logic          enable;
  logic          clear;
  logic          ain;
  logic          yout;
  logic [CW-1:0] count;
  logic          busy;

  modport master (output enable, clear, ain, input yout, count, busy);
  modport slave  (input enable, clear, ain, output yout, count, busy);
endinterface

// File: rtl/modn_event_counter_fsm.sv
// Modulo-MODULUS event counter: counts qualified ain events (level or rising edge)
// and flags every MODULUS-th one on yout, either registered (Moore) or same-cycle (Mealy).
module modn_event_counter_fsm #(
  parameter int MODULUS   = 3,
  parameter bit EDGE_MODE = 1'b0,
  parameter bit OUT_MODE  = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  modn_event_counter_fsm_if.slave     bus
);
  localparam int            CW   = $clog2(MODULUS);
  localparam logic [CW-1:0] LAST = CW'(MODULUS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    TERM  = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          ain_q;
  logic          evt;

  assign evt = EDGE_MODE ? (bus.enable & bus.ain & ~ain_q) : (bus.enable & bus.ain);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (evt) begin
            state_d = ACCUM;
            count_d = ONE;
          end else begin
            count_d = '0;
          end
        end
        ACCUM: begin
          if (evt && count_q == LAST) begin
            state_d = TERM;
            count_d = '0;
          end else if (evt) begin
            count_d = count_q + ONE;
          end
        end
        TERM: begin
          // TERM is a one-cycle state and exits even when enable is low.
          if (evt) begin
            state_d = ACCUM;
            count_d = ONE;
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ain_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ain_q   <= bus.ain;
    end
  end

  always_comb begin
    if (OUT_MODE) begin
      bus.yout = (state_q == ACCUM) && (count_q == LAST) && evt && !reset && !bus.clear;
    end else begin
      bus.yout = (state_q == TERM);
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q != IDLE);
endmodule
